vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz VGA raster timing that the screen-drawing controllers consume: hCount, vCount, bright, hSync and vSync.
- Runs on the 100 MHz board clock and divides it down internally to a 25 MHz pixel-enable rate.
- Also provides a one-cycle frame_tick, which game-logic blocks use as their slow update strobe.
- Sits between the board clock/reset and every pixel-colour controller; the top level routes hSync/vSync to the connector.

Parameters:
- CLK_DIV, 4, board clocks per pixel (≥1; 1 = pix_tick always high).
- H_TOTAL, 800, pixel periods per line.
- H_SYNC, 96, hSync low width in pixels.
- H_DISP_START, 144, first visible hCount.
- H_DISP_END, 783, last visible hCount.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines.
- V_DISP_START, 35, first visible vCount.
- V_DISP_END, 514, last visible vCount.

Ports:
- clk  in  1  board clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- hCount  out  10  horizontal position, 0..H_TOTAL-1.
- vCount  out  10  vertical position, 0..V_TOTAL-1.
- bright  out  1  high inside the visible window.
- hSync  out  1  active-low horizontal sync.
- vSync  out  1  active-low vertical sync.
- pix_tick  out  1  one-clk pixel-enable strobe.
- frame_tick  out  1  one-clk strobe on the last pixel of each frame.
- frame_count  out  8  frames elapsed; present only with VGA_FRAME_CNT_EN.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous, active-low; assertion clears all state immediately, release is sampled on the next clk rising edge.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_tick = (div==CLK_DIV-1), combinational.
- Horizontal counter: advances only on pix_tick. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on pix_tick with hCount==H_TOTAL-1. At V_TOTAL-1 it wraps to 0.
- hSync, vSync and bright are registers loaded on the same edge as the counters, computed from the next counter values. They are therefore always consistent with the hCount/vCount presented in the same cycle (zero lag).
  - hSync = ~(hCount < H_SYNC).
  - vSync = ~(vCount < V_SYNC).
  - bright = (H_DISP_START ≤ hCount ≤ H_DISP_END) && (V_DISP_START ≤ vCount ≤ V_DISP_END).
- frame_tick = pix_tick && hCount==H_TOTAL-1 && vCount==V_TOTAL-1. Combinational, exactly one clk per frame, in the cycle before both counters wrap.
- Reset values:
  - div=0, hCount=0, vCount=0.
  - hSync=0, vSync=0 (counter 0 lies in the sync region).
  - bright=0, frame_tick=0, frame_count=0.
- First pix_tick occurs CLK_DIV clks after reset release.
- Reset mid-frame: counters return to 0 immediately and asynchronously; the frame restarts from the sync pulse. No partial-line recovery.
- Counters never reach out-of-range values. Any value ≥ its TOTAL, which is unreachable, wraps to 0 on the next advance.
- All comparisons are unsigned 10-bit; parameters must fit in 10 bits.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - frame_count port exists, 8-bit, increments on each frame_tick edge.
  - Wraps 255→0; reset to 0.
  - Used for blinking cursors and win animations.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 localparams (H_TOTAL, H_SYNC, H_DISP_START/END, V_TOTAL, V_SYNC, V_DISP_START/END);
  - a 10-bit coord_t typedef, shared with the pixel controllers so their region math uses the same window.
- One sub-module: clk_en_div (parameter DIV).
  - Holds the div counter; outputs the one-clk enable pulse.
  - Reusable for button-sampling strobes.

Test Plan:
- Reset release, CLK_DIV=4:
  - pix_tick first high on clk 4, then every 4 clks.
  - hCount reads 1 after the 4th edge.
- Horizontal timing:
  - hSync low for exactly 384 clks (96×4) starting at hCount=0, then high for 2816 clks.
  - Line period is 3200 clks.
- Frame timing:
  - frame_tick pulses once per 1,680,000 clks.
  - vSync low for 6400 clks (2 lines).
  - vCount and hCount both read 0 the cycle after frame_tick.
- Visible window:
  - bright first rises with hCount=144, vCount=35.
  - bright falls after hCount=783 and stays low on vCount 515..524.
  - Exactly 640×480=307,200 pixel periods have bright=1 per frame.
- Asynchronous reset: assert rst=0 mid-frame at hCount=500, vCount=200, between clk edges.
  - Counters read 0 and hSync=0 before the next edge.
  - Normal timing resumes after release.
- VGA_FRAME_CNT_EN defined:
  - frame_count reads 3 after 3 frame_ticks.
  - Wraps to 0 after the 256th frame_tick.
  - Build without the macro elaborates with no frame_count port.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants and the coordinate type
// used by the timing generator and the pixel-colour controllers.
//   coord_t  : 10-bit unsigned raster coordinate
//   in_range : inclusive window test used for the visible-area decode
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int CLK_DIV      = 4;
  localparam int H_TOTAL      = 800;
  localparam int H_SYNC       = 96;
  localparam int H_DISP_START = 144;
  localparam int H_DISP_END   = 783;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC       = 2;
  localparam int V_DISP_START = 35;
  localparam int V_DISP_END   = 514;

  function automatic logic in_range(input coord_t x, input coord_t lo, input coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from the generator to its consumers.
//   hCount/vCount : current raster position
//   bright        : inside the visible window
//   hSync/vSync   : active-low sync
//   pix_tick      : one-clk pixel enable
//   frame_tick    : one-clk strobe on the last pixel of a frame
//   frame_count   : frames elapsed (only with VGA_FRAME_CNT_EN)
// modport master drives the bundle, slave observes it.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t     hCount;
  coord_t     vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       pix_tick;
  logic       frame_tick;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
    output hCount, vCount, bright, hSync, vSync, pix_tick, frame_tick
`ifdef VGA_FRAME_CNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input hCount, vCount, bright, hSync, vSync, pix_tick, frame_tick
`ifdef VGA_FRAME_CNT_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/clk_en_div.sv
// clk_en_div: free-running clock-enable divider.
//   clk  : clock
//   rst  : async active-low reset
//   tick : high for one clk every DIV clks, first after DIV-1 edges from reset
// DIV=1 degenerates to a constant-high enable with no counter.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  if (DIV <= 1) begin : g_passthru
    assign tick = 1'b1;
  end else begin : g_cnt
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         cnt <= '0;
      else if (cnt >= CW'(DIV - 1))     cnt <= '0;
      else                              cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CW'(DIV - 1));
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 100 MHz board clock.
//   clk : board clock
//   rst : async active-low reset
//   vif : vga_timing_if.master (hCount, vCount, bright, hSync, vSync,
//         pix_tick, frame_tick, and frame_count when VGA_FRAME_CNT_EN is defined)
// Optional feature macro: VGA_FRAME_CNT_EN adds an 8-bit wrapping frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV      = vga_timing_pkg::CLK_DIV,
  parameter int H_TOTAL      = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_DISP_START = vga_timing_pkg::H_DISP_START,
  parameter int H_DISP_END   = vga_timing_pkg::H_DISP_END,
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_DISP_START = vga_timing_pkg::V_DISP_START,
  parameter int V_DISP_END   = vga_timing_pkg::V_DISP_END
) (
  input  logic           clk,
  input  logic           rst,
  vga_timing_if.master   vif
);
  import vga_timing_pkg::*;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_SY   = coord_t'(H_SYNC);
  localparam coord_t V_SY   = coord_t'(V_SYNC);
  localparam coord_t H_DS   = coord_t'(H_DISP_START);
  localparam coord_t H_DE   = coord_t'(H_DISP_END);
  localparam coord_t V_DS   = coord_t'(V_DISP_START);
  localparam coord_t V_DE   = coord_t'(V_DISP_END);

  logic   pix_tick;
  coord_t h_q, v_q, h_d, v_d;
  logic   h_wrap, v_wrap;
  logic   hsync_q, vsync_q, bright_q;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick)
  );

  // >= rather than == so an out-of-range value can only ever wrap to 0.
  always_comb begin
    h_wrap = (h_q >= H_LAST);
    v_wrap = (v_q >= V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_tick) begin
      h_d = h_wrap ? '0 : h_q + coord_t'(1);
      if (h_wrap) v_d = v_wrap ? '0 : v_q + coord_t'(1);
    end
  end

  // Sync/bright decode from the next counter values so they line up with
  // the counters they are presented alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= (h_d >= H_SY);
      vsync_q  <= (v_d >= V_SY);
      bright_q <= in_range(h_d, H_DS, H_DE) && in_range(v_d, V_DS, V_DE);
    end
  end

  assign vif.hCount     = h_q;
  assign vif.vCount     = v_q;
  assign vif.hSync      = hsync_q;
  assign vif.vSync      = vsync_q;
  assign vif.bright     = bright_q;
  assign vif.pix_tick   = pix_tick;
  assign vif.frame_tick = pix_tick && (h_q == H_LAST) && (v_q == V_LAST);

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                fcnt_q <= '0;
    else if (vif.frame_tick) fcnt_q <= fcnt_q + 8'd1;
  end

  assign vif.frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster so whole frames fit in a
// short run. Reference model: every output is derived from the number of
// clock edges since reset release using division/modulo arithmetic.
module tb_vga_timing_gen;

  localparam int DIV = 2;
  localparam int HT  = 12, HS = 2, HDS = 3, HDE = 10;
  localparam int VT  = 8,  VS = 2, VDS = 2, VDE = 6;
  localparam int LINE  = HT * DIV;
  localparam int FRAME = HT * VT * DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vga_timing_if vif ();

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS), .H_DISP_START(HDS), .H_DISP_END(HDE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_DISP_START(VDS), .V_DISP_END(VDE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  always #5 clk = ~clk;

  int n;        // rising edges since reset release
  int vectors;
  int errors;

  // {hCount, vCount, bright, hSync, vSync, pix_tick, frame_tick}
  function automatic logic [24:0] model(input int k);
    int p, h, v;
    logic br, hs, vs, pt, ft;
    p  = k / DIV;
    h  = p % HT;
    v  = (p / HT) % VT;
    pt = (k % DIV) == DIV - 1;
    br = (h >= HDS) && (h <= HDE) && (v >= VDS) && (v <= VDE);
    hs = (h >= HS);
    vs = (v >= VS);
    ft = pt && (h == HT - 1) && (v == VT - 1);
    return {10'(h), 10'(v), br, hs, vs, pt, ft};
  endfunction

  function automatic logic [24:0] observe();
    return {vif.hCount, vif.vCount, vif.bright, vif.hSync, vif.vSync,
            vif.pix_tick, vif.frame_tick};
  endfunction

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst = 1'b1;
    n   = 0;
  endtask

  task automatic test_reset();
    int first_tick;
    first_tick = -1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (observe() !== model(0)) begin
      errors++;
      $display("FAIL reset_state got %h want %h", observe(), model(0));
    end
    rst = 1'b1;
    n   = 0;
    for (int i = 0; i < 3 * DIV + 1; i++) begin
      if (i > 0) step();
      vectors++;
      if (observe() !== model(n)) begin
        errors++;
        $display("FAIL release_cycle n=%0d got %h want %h", n, observe(), model(n));
      end
      if (vif.pix_tick && first_tick < 0) first_tick = n;
      if (n == DIV) begin
        vectors++;
        if (vif.hCount !== 10'd1) begin
          errors++;
          $display("FAIL first_advance got %0d want 1", vif.hCount);
        end
      end
    end
    vectors++;
    if (first_tick != DIV - 1) begin
      errors++;
      $display("FAIL first_pix_tick got %0d want %0d", first_tick, DIV - 1);
    end
  endtask

  task automatic test_horizontal();
    int lo, hi, w1, w2;
    int prev_h;
    lo = 0; hi = 0; w1 = -1; w2 = -1; prev_h = -1;
    restart();
    for (int i = 0; i <= 2 * LINE; i++) begin
      if (i > 0) step();
      vectors++;
      if (observe() !== model(n)) begin
        errors++;
        $display("FAIL horiz_cycle n=%0d got %h want %h", n, observe(), model(n));
      end
      if (i < LINE) begin
        if (vif.hSync) hi++; else lo++;
      end
      if (prev_h == HT - 1 && vif.hCount == 0) begin
        if (w1 < 0) w1 = n; else if (w2 < 0) w2 = n;
      end
      prev_h = int'(vif.hCount);
    end
    vectors++;
    if (lo != HS * DIV) begin
      errors++;
      $display("FAIL hsync_low_clks got %0d want %0d", lo, HS * DIV);
    end
    vectors++;
    if (hi != (HT - HS) * DIV) begin
      errors++;
      $display("FAIL hsync_high_clks got %0d want %0d", hi, (HT - HS) * DIV);
    end
    vectors++;
    if (w2 - w1 != LINE || w1 != LINE) begin
      errors++;
      $display("FAIL line_period got %0d..%0d want %0d..%0d", w1, w2, LINE, 2 * LINE);
    end
  endtask

  task automatic test_frame();
    int vlo, brt, ticks, t1, t2, rise_h, rise_v;
    logic prev_ft, prev_br;
    vlo = 0; brt = 0; ticks = 0; t1 = -1; t2 = -1; rise_h = -1; rise_v = -1;
    prev_ft = 1'b0; prev_br = 1'b0;
    restart();
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (i > 0) step();
      vectors++;
      if (observe() !== model(n)) begin
        errors++;
        $display("FAIL frame_cycle n=%0d got %h want %h", n, observe(), model(n));
      end
      if (prev_ft) begin
        vectors++;
        if (vif.hCount !== 10'd0 || vif.vCount !== 10'd0) begin
          errors++;
          $display("FAIL wrap_after_tick got %0d,%0d want 0,0", vif.hCount, vif.vCount);
        end
      end
      if (vif.bright && !prev_br && rise_h < 0) begin
        rise_h = int'(vif.hCount);
        rise_v = int'(vif.vCount);
      end
      if (i < FRAME) begin
        if (!vif.vSync) vlo++;
        if (vif.bright && vif.pix_tick) brt++;
        if (vif.frame_tick) ticks++;
      end
      if (vif.frame_tick) begin
        if (t1 < 0) t1 = n; else if (t2 < 0) t2 = n;
      end
      prev_ft = vif.frame_tick;
      prev_br = vif.bright;
    end
    vectors++;
    if (vlo != VS * LINE) begin
      errors++;
      $display("FAIL vsync_low_clks got %0d want %0d", vlo, VS * LINE);
    end
    vectors++;
    if (brt != (HDE - HDS + 1) * (VDE - VDS + 1)) begin
      errors++;
      $display("FAIL bright_pixels got %0d want %0d", brt, (HDE - HDS + 1) * (VDE - VDS + 1));
    end
    vectors++;
    if (ticks != 1 || t2 - t1 != FRAME || t1 != FRAME - 1) begin
      errors++;
      $display("FAIL frame_tick got %0d ticks at %0d,%0d want 1 at %0d,%0d",
               ticks, t1, t2, FRAME - 1, 2 * FRAME - 1);
    end
    vectors++;
    if (rise_h != HDS || rise_v != VDS) begin
      errors++;
      $display("FAIL bright_rise got %0d,%0d want %0d,%0d", rise_h, rise_v, HDS, VDS);
    end
  endtask

  task automatic test_async_reset();
    int r;
    for (int rep = 0; rep < 4; rep++) begin
      restart();
      r = $urandom_range(LINE + 1, FRAME - 2);
      for (int i = 0; i < r; i++) begin
        step();
        vectors++;
        if (observe() !== model(n)) begin
          errors++;
          $display("FAIL pre_reset n=%0d got %h want %h", n, observe(), model(n));
        end
      end
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (observe() !== model(0)) begin
        errors++;
        $display("FAIL async_clear got %h want %h", observe(), model(0));
      end
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        vectors++;
        if (observe() !== model(0)) begin
          errors++;
          $display("FAIL reset_hold got %h want %h", observe(), model(0));
        end
      end
      rst = 1'b1;
      n   = 0;
      for (int i = 0; i < LINE + 3; i++) begin
        step();
        vectors++;
        if (observe() !== model(n)) begin
          errors++;
          $display("FAIL post_reset n=%0d got %h want %h", n, observe(), model(n));
        end
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_count();
    logic [7:0] exp_fc;
    restart();
    for (int i = 0; i <= 256 * FRAME + 2; i++) begin
      if (i > 0) step();
      exp_fc = 8'((n / DIV) / (HT * VT));
      vectors++;
      if (vif.frame_count !== exp_fc) begin
        errors++;
        $display("FAIL frame_count n=%0d got %0d want %0d", n, vif.frame_count, exp_fc);
      end
      if (n == 3 * FRAME) begin
        vectors++;
        if (vif.frame_count !== 8'd3) begin
          errors++;
          $display("FAIL frame_count_3 got %0d want 3", vif.frame_count);
        end
      end
      if (n == 256 * FRAME) begin
        vectors++;
        if (vif.frame_count !== 8'd0) begin
          errors++;
          $display("FAIL frame_count_wrap got %0d want 0", vif.frame_count);
        end
      end
    end
  endtask
`endif

  initial begin
    n = 0; vectors = 0; errors = 0;
    test_reset();
    test_horizontal();
    test_frame();
    test_async_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
